// File: rtl/gshare_branch_predictor.sv
// gshare branch predictor for the fetch stage.
// A table of 2-bit counters is indexed by the fetch PC XORed with the speculative
// global history. A direct-mapped BTB supplies targets and decides which PCs are branches.
// The resolve stage trains the tables, repairs the history on a mispredict and
// supplies the redirect PC. Saturating counters track branch and mispredict totals.
module gshare_branch_predictor #(
    parameter int          PC_W      = 8,
    parameter int          PHT_IDX_W = 6,
    parameter int          BTB_IDX_W = 4,
    parameter logic [1:0]  PHT_INIT  = 2'b01,
    parameter int          STAT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [PC_W-1:0]      fetch_pc,
    output logic                 pred_taken,
    output logic [PC_W-1:0]      pred_target,
    output logic [PHT_IDX_W-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [PC_W-1:0]      upd_pc,
    input  logic [PHT_IDX_W-1:0] upd_ghr,
    input  logic                 upd_pred,
    input  logic                 upd_taken,
    input  logic [PC_W-1:0]      upd_target,
    output logic                 mispredict,
    output logic [PC_W-1:0]      corrected_pc,
    output logic [STAT_W-1:0]    stat_branches,
    output logic [STAT_W-1:0]    stat_mispred
);

    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = PC_W - BTB_IDX_W;

    logic [1:0]           pht_q        [PHT_N];
    logic [1:0]           pht_d        [PHT_N];
    logic                 btb_valid_q  [BTB_N];
    logic                 btb_valid_d  [BTB_N];
    logic [TAG_W-1:0]     btb_tag_q    [BTB_N];
    logic [TAG_W-1:0]     btb_tag_d    [BTB_N];
    logic [PC_W-1:0]      btb_target_q [BTB_N];
    logic [PC_W-1:0]      btb_target_d [BTB_N];
    logic [PHT_IDX_W-1:0] ghr_q, ghr_d;
    logic [STAT_W-1:0]    stat_branches_q, stat_branches_d;
    logic [STAT_W-1:0]    stat_mispred_q, stat_mispred_d;

    logic [PHT_IDX_W-1:0] fidx;
    logic [BTB_IDX_W-1:0] fbidx;
    logic                 btb_hit;
    logic                 pht_taken;
    logic [PHT_IDX_W-1:0] uidx;
    logic [BTB_IDX_W-1:0] ubidx;

    // Fetch-side lookup; the result is computed from the stored state before any same-cycle training.
    always_comb begin
        fidx        = fetch_pc[PHT_IDX_W-1:0] ^ ghr_q;
        fbidx       = fetch_pc[BTB_IDX_W-1:0];
        btb_hit     = btb_valid_q[fbidx] && (btb_tag_q[fbidx] == fetch_pc[PC_W-1:BTB_IDX_W]);
        pht_taken   = btb_hit && pht_q[fidx][1];
        pred_taken  = reset && !stall && pht_taken;
        pred_target = pred_taken ? btb_target_q[fbidx] : fetch_pc + PC_W'(1);
        pred_ghr    = ghr_q;
    end

    // Resolve-side outcome check and redirect PC; held quiet while in reset.
    always_comb begin
        mispredict   = reset && upd_valid && (upd_pred != upd_taken);
        corrected_pc = upd_taken ? upd_target : upd_pc + PC_W'(1);
        uidx         = upd_pc[PHT_IDX_W-1:0] ^ upd_ghr;
        ubidx        = upd_pc[BTB_IDX_W-1:0];
    end

    // Next speculative history: a repair wins over a fetch-side shift; only BTB hits shift.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = {upd_ghr[PHT_IDX_W-2:0], upd_taken};
        end else if (!stall && btb_hit) begin
            ghr_d = {ghr_q[PHT_IDX_W-2:0], pht_taken};
        end
    end

    // Training of the counter table and BTB allocation on taken branches.
    always_comb begin
        pht_d        = pht_q;
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        if (upd_valid) begin
            if (upd_taken) begin
                if (pht_q[uidx] != 2'b11) begin
                    pht_d[uidx] = pht_q[uidx] + 2'b01;
                end
                btb_valid_d[ubidx]  = 1'b1;
                btb_tag_d[ubidx]    = upd_pc[PC_W-1:BTB_IDX_W];
                btb_target_d[ubidx] = upd_target;
            end else if (pht_q[uidx] != 2'b00) begin
                pht_d[uidx] = pht_q[uidx] - 2'b01;
            end
        end
    end

    // Saturating statistics counters.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (upd_valid && (stat_branches_q != {STAT_W{1'b1}})) begin
            stat_branches_d = stat_branches_q + STAT_W'(1);
        end
        if (mispredict && (stat_mispred_q != {STAT_W{1'b1}})) begin
            stat_mispred_d = stat_mispred_q + STAT_W'(1);
        end
    end

    // Counter table register; reset reloads every counter to weakly not taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= PHT_INIT;
            end
        end else begin
            pht_q <= pht_d;
        end
    end

    // BTB register; only valid bits need clearing, tags and targets are don't-care while invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
        end else begin
            btb_valid_q  <= btb_valid_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
        end
    end

    // History and statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q           <= '0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            ghr_q           <= ghr_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Testbench for gshare_branch_predictor: directed scenarios plus randomized traffic
// checked against a behavioural model built from plain integer arrays.
module tb_gshare_branch_predictor;

    localparam int PC_W      = 8;
    localparam int PHT_IDX_W = 6;
    localparam int BTB_IDX_W = 4;
    localparam int STAT_W    = 10;
    localparam int STAT_MAX  = (1 << STAT_W) - 1;

    logic                 clk;
    logic                 reset;
    logic                 stall;
    logic [PC_W-1:0]      fetch_pc;
    logic                 pred_taken;
    logic [PC_W-1:0]      pred_target;
    logic [PHT_IDX_W-1:0] pred_ghr;
    logic                 upd_valid;
    logic [PC_W-1:0]      upd_pc;
    logic [PHT_IDX_W-1:0] upd_ghr;
    logic                 upd_pred;
    logic                 upd_taken;
    logic [PC_W-1:0]      upd_target;
    logic                 mispredict;
    logic [PC_W-1:0]      corrected_pc;
    logic [STAT_W-1:0]    stat_branches;
    logic [STAT_W-1:0]    stat_mispred;

    gshare_branch_predictor #(
        .PC_W      (PC_W),
        .PHT_IDX_W (PHT_IDX_W),
        .BTB_IDX_W (BTB_IDX_W),
        .PHT_INIT  (2'b01),
        .STAT_W    (STAT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .fetch_pc      (fetch_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_ghr      (pred_ghr),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_ghr       (upd_ghr),
        .upd_pred      (upd_pred),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .mispredict    (mispredict),
        .corrected_pc  (corrected_pc),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: counters 0..3, BTB as valid/tag/target arrays, history as an integer.
    int pht [64];
    bit bv [16];
    int btag [16];
    int btgt [16];
    int ghr;
    int sb;
    int sm;

    // Expected outputs for the current cycle and the fetch-side facts the history update needs.
    int  e_taken, e_target, e_ghr, e_mis, e_corr;
    bit  m_hit;
    int  m_ptk;

    // DUT values sampled during the last applyStimulus call, for scenario-specific constant checks.
    int last_taken, last_target, last_mis, last_corr;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 64; i++) pht[i] = 1;
        for (int i = 0; i < 16; i++) begin
            bv[i]   = 1'b0;
            btag[i] = 0;
            btgt[i] = 0;
        end
        ghr = 0;
        sb  = 0;
        sm  = 0;
    endfunction

    function automatic int modelPredictPc(input int pc);
        int bi;
        bi = pc % 16;
        if (bv[bi] && btag[bi] == pc / 16 && pht[(pc % 64) ^ ghr] >= 2) return 1;
        return 0;
    endfunction

    function automatic void modelPredict();
        int pc, bi, fi;
        pc      = int'(fetch_pc);
        bi      = pc % 16;
        fi      = (pc % 64) ^ ghr;
        m_hit   = bv[bi] && (btag[bi] == pc / 16);
        m_ptk   = (m_hit && pht[fi] >= 2) ? 1 : 0;
        e_taken = (!stall && m_ptk == 1) ? 1 : 0;
        e_target = (e_taken == 1) ? btgt[bi] : (pc + 1) % 256;
        e_ghr   = ghr;
        e_mis   = (upd_valid && (upd_pred != upd_taken)) ? 1 : 0;
        e_corr  = upd_taken ? int'(upd_target) : (int'(upd_pc) + 1) % 256;
    endfunction

    function automatic void modelCommit();
        int ui, bi;
        if (e_mis == 1) ghr = ((int'(upd_ghr) * 2) + int'(upd_taken)) % 64;
        else if (!stall && m_hit) ghr = ((ghr * 2) + m_ptk) % 64;
        if (upd_valid) begin
            ui = (int'(upd_pc) % 64) ^ int'(upd_ghr);
            if (upd_taken) begin
                if (pht[ui] < 3) pht[ui]++;
                bi       = int'(upd_pc) % 16;
                bv[bi]   = 1'b1;
                btag[bi] = int'(upd_pc) / 16;
                btgt[bi] = int'(upd_target);
            end else if (pht[ui] > 0) begin
                pht[ui]--;
            end
            if (sb < STAT_MAX) sb++;
        end
        if (e_mis == 1 && sm < STAT_MAX) sm++;
    endfunction

    // One clock of stimulus: drive, compare every output against the model, then step the model at the edge.
    task automatic applyStimulus(input bit s, input int fpc, input bit uv, input int upc,
                                 input int ughr, input bit up, input bit ut, input int utgt);
        stall      = s;
        fetch_pc   = PC_W'(fpc);
        upd_valid  = uv;
        upd_pc     = PC_W'(upc);
        upd_ghr    = PHT_IDX_W'(ughr);
        upd_pred   = up;
        upd_taken  = ut;
        upd_target = PC_W'(utgt);
        #3;
        modelPredict();
        checkOutput("pred_taken", int'(pred_taken), e_taken);
        checkOutput("pred_target", int'(pred_target), e_target);
        checkOutput("pred_ghr", int'(pred_ghr), e_ghr);
        checkOutput("mispredict", int'(mispredict), e_mis);
        checkOutput("corrected_pc", int'(corrected_pc), e_corr);
        checkOutput("stat_branches", int'(stat_branches), sb);
        checkOutput("stat_mispred", int'(stat_mispred), sm);
        last_taken  = int'(pred_taken);
        last_target = int'(pred_target);
        last_mis    = int'(mispredict);
        last_corr   = int'(corrected_pc);
        @(posedge clk);
        modelCommit();
        #1;
    endtask

    // Asynchronous reset pulse in the middle of a cycle with a pending mispredict on the inputs.
    task automatic pulseReset(input int fpc);
        stall     = 1'b0;
        fetch_pc  = PC_W'(fpc);
        upd_valid = 1'b1;
        upd_pc    = PC_W'(fpc);
        upd_pred  = 1'b0;
        upd_taken = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_pred_taken", int'(pred_taken), 0);
        checkOutput("rst_pred_target", int'(pred_target), (fpc + 1) % 256);
        checkOutput("rst_mispredict", int'(mispredict), 0);
        checkOutput("rst_pred_ghr", int'(pred_ghr), 0);
        checkOutput("rst_stat_branches", int'(stat_branches), 0);
        upd_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int pcs [6] = '{8'h10, 8'h05, 8'h30, 8'hFF, 8'h14, 8'h50};

    initial begin
        int pc, saved_ghr;
        reset = 1'b0;
        stall = 1'b0;
        fetch_pc = 8'h10;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_ghr = '0;
        upd_pred = 1'b0;
        upd_taken = 1'b0;
        upd_target = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state lookup
        applyStimulus(0, 8'h10, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_target_const", last_target, 8'h11);
        checkOutput("reset_taken_const", last_taken, 0);

        // First taken resolve of 0x10 mispredicts and repairs history to 000001
        applyStimulus(0, 8'h10, 1, 8'h10, 0, 0, 1, 8'h20);
        checkOutput("first_mis_const", last_mis, 1);
        checkOutput("first_corr_const", last_corr, 8'h20);
        checkOutput("first_ghr_const", int'(pred_ghr), 1);
        applyStimulus(0, 8'h10, 1, 8'h10, 0, 0, 1, 8'h20);

        // Stall with a BTB hit holds history and suppresses the prediction
        saved_ghr = ghr;
        applyStimulus(1, 8'h10, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_taken_const", last_taken, 0);
        checkOutput("stall_ghr_hold", int'(pred_ghr), saved_ghr);

        // Mispredict repair wins over a same-cycle BTB-hit fetch shift
        applyStimulus(0, 8'h10, 1, 8'h30, 5, 0, 1, 8'h40);
        checkOutput("repair_ghr_const", int'(pred_ghr), 11);

        // Loop branch at 0x05 -> 0x02 taken eight times, then exits
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 8'h05, 1, 8'h05, ghr, modelPredictPc(8'h05) == 1, 1, 8'h02);
        end
        applyStimulus(0, 8'h05, 0, 0, 0, 0, 0, 0);
        checkOutput("loop_target_const", last_target, 8'h02);
        applyStimulus(0, 8'h05, 1, 8'h05, ghr, 1, 0, 8'h02);
        checkOutput("loop_exit_mis_const", last_mis, 1);
        checkOutput("loop_exit_corr_const", last_corr, 8'h06);
        checkOutput("loop_exit_ghr_lsb", int'(pred_ghr) % 2, 0);

        // Counter saturation: drive one entry to 11 then five not-taken updates
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 8'h30, 0, 1, 1, 8'h31);
        for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 1, 8'h30, 0, 0, 0, 8'h31);

        // Wrap of the fall-through PC
        applyStimulus(0, 8'hFF, 1, 8'hFF, 0, 1, 0, 8'h40);
        checkOutput("wrap_corr_const", last_corr, 8'h00);
        applyStimulus(0, 8'hFF, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap_fetch_const", last_target, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            pc = pcs[$urandom_range(0, 5)];
            applyStimulus($urandom_range(0, 4) == 0, pcs[$urandom_range(0, 5)],
                          $urandom_range(0, 2) != 0, pc,
                          ($urandom_range(0, 1) == 1) ? ghr : int'($urandom_range(0, 63)),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                          (pc + 1 + int'($urandom_range(0, 40))) % 256);
        end

        // Reset mid-sequence discards training
        pulseReset(8'h05);
        applyStimulus(0, 8'h05, 0, 0, 0, 0, 0, 0);
        checkOutput("post_reset_taken_const", last_taken, 0);
        checkOutput("post_reset_target_const", last_target, 8'h06);

        // Statistics saturation
        for (int i = 0; i < STAT_MAX + 4; i++) begin
            applyStimulus(0, 8'h20, 1, 8'h20, 0, 1, 0, 8'h21);
        end
        checkOutput("stat_mispred_sat", int'(stat_mispred), STAT_MAX);
        checkOutput("stat_branches_sat", int'(stat_branches), STAT_MAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
